// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit.
//   Op codes presented by EX, plus the resolver state encoding.
package branch_resolve_pkg;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_BLEZ = 3'd3;
  localparam logic [2:0] OP_BGTZ = 3'd4;
  localparam logic [2:0] OP_BLTZ = 3'd5;
  localparam logic [2:0] OP_BGEZ = 3'd6;
  localparam logic [2:0] OP_JUMP = 3'd7;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_cond.sv
// Combinational branch condition evaluator.
//   op_i     : branch op code
//   eq_i..sgte_i : comparator flags for the instruction
//   taken_o  : branch outcome (0 for OP_NONE)
module branch_resolve_cond
  import branch_resolve_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic       eq_i,
  input  logic       neq_i,
  input  logic       slt_i,
  input  logic       slte_i,
  input  logic       sgt_i,
  input  logic       sgte_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    unique case (op_i)
      OP_NONE: taken_o = 1'b0;
      OP_BEQ:  taken_o = eq_i;
      OP_BNE:  taken_o = neq_i;
      OP_BLEZ: taken_o = slte_i;
      OP_BGTZ: taken_o = sgt_i;
      OP_BLTZ: taken_o = slt_i;
      OP_BGEZ: taken_o = sgte_i;
      OP_JUMP: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit.
//   Accepts a branch from EX (in_valid/in_ready), evaluates its condition,
//   compares with the fetch prediction and, on a mispredict, pulses flush
//   and holds a redirect to fetch until redir_ready. Every resolution is
//   reported on res_valid/res_taken; br_count/mis_count saturate.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : EX handshake (in_ready only depends on state)
//   in_op, in_pc4, in_target, in_pred_taken : branch metadata
//   eq..sgte             : comparator flags
//   redir_valid/ready/pc : redirect handshake to fetch
//   flush                : one-cycle kill of younger instructions
//   res_valid, res_taken : resolution report to the predictor
//   cnt_clr              : synchronous counter clear (wins over increment)
//   br_count, mis_count  : saturating performance counters
//
// state    | meaning
// IDLE     | ready to accept an instruction from EX
// REDIRECT | mispredict outstanding; redirect held until fetch accepts
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_pc4,
  input  logic [WIDTH-1:0] in_target,
  input  logic             in_pred_taken,
  input  logic             eq,
  input  logic             neq,
  input  logic             slt,
  input  logic             slte,
  input  logic             sgt,
  input  logic             sgte,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [WIDTH-1:0] redir_pc,
  output logic             flush,
  output logic             res_valid,
  output logic             res_taken,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic             flush_q, flush_d;
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] mis_q, mis_d;

  logic taken;
  logic accept;
  logic is_br;
  logic mispredict;

  branch_resolve_cond u_cond (
    .op_i    (in_op),
    .eq_i    (eq),
    .neq_i   (neq),
    .slt_i   (slt),
    .slte_i  (slte),
    .sgt_i   (sgt),
    .sgte_i  (sgte),
    .taken_o (taken)
  );

  assign accept     = in_valid && (state_q == IDLE);
  assign is_br      = (in_op != OP_NONE);
  assign mispredict = is_br && (taken != in_pred_taken);

  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redir_pc_q;
    flush_d     = 1'b0;
    res_valid_d = 1'b0;
    res_taken_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && is_br) begin
          res_valid_d = 1'b1;
          res_taken_d = taken;
          if (mispredict) begin
            flush_d    = 1'b1;
            state_d    = REDIRECT;
            redir_pc_d = taken ? in_target : in_pc4;
          end
        end
      end
      REDIRECT: begin
        // Anything EX offers now is wrong-path; only the fetch handshake matters.
        if (redir_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters advance on the accept edge so they line up with res_valid.
  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (cnt_clr) begin
      br_d  = '0;
      mis_d = '0;
    end else if (accept && is_br) begin
      if (br_q != CNT_MAX) br_d = br_q + 1'b1;
      if (mispredict && (mis_q != CNT_MAX)) mis_d = mis_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      redir_pc_q  <= '0;
      flush_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      br_q        <= '0;
      mis_q       <= '0;
    end else begin
      state_q     <= state_d;
      redir_pc_q  <= redir_pc_d;
      flush_q     <= flush_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      br_q        <= br_d;
      mis_q       <= mis_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign redir_valid = (state_q == REDIRECT);
  assign redir_pc    = redir_pc_q;
  assign flush       = flush_q;
  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign br_count    = br_q;
  assign mis_count   = mis_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (CNT_W=4 build).
module tb_branch_resolve;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_pc4;
  logic [WIDTH-1:0] in_target;
  logic             in_pred_taken;
  logic             eq, neq, slt, slte, sgt, sgte;
  logic             redir_valid;
  logic             redir_ready;
  logic [WIDTH-1:0] redir_pc;
  logic             flush;
  logic             res_valid;
  logic             res_taken;
  logic             cnt_clr;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  int checks = 0;
  int errors = 0;

  branch_resolve #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_pc4        (in_pc4),
    .in_target     (in_target),
    .in_pred_taken (in_pred_taken),
    .eq            (eq),
    .neq           (neq),
    .slt           (slt),
    .slte          (slte),
    .sgt           (sgt),
    .sgte          (sgte),
    .redir_valid   (redir_valid),
    .redir_ready   (redir_ready),
    .redir_pc      (redir_pc),
    .flush         (flush),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .cnt_clr       (cnt_clr),
    .br_count      (br_count),
    .mis_count     (mis_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc4,
                       input logic [31:0] tgt, input logic pred, input logic [5:0] flags);
    in_valid      = v;
    in_op         = op;
    in_pc4        = pc4;
    in_target     = tgt;
    in_pred_taken = pred;
    {eq, neq, slt, slte, sgt, sgte} = flags;
  endtask

  initial begin
    rst_n = 1'b0;
    redir_ready = 1'b0;
    cnt_clr = 1'b0;
    drive(1'b1, 3'd7, 32'h10, 32'h20, 1'b0, 6'b0);
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_redir_valid", redir_valid, 0);
    check("rst_redir_pc", redir_pc, 0);
    check("rst_flush", flush, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_taken", res_taken, 0);
    check("rst_br", br_count, 0);
    check("rst_mis", mis_count, 0);
    drive(1'b0, 3'd0, 0, 0, 1'b0, 6'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // BEQ taken, predicted taken
    drive(1'b1, 3'd1, 32'h104, 32'h400, 1'b1, 6'b100000);
    tick();
    drive(1'b0, 3'd0, 0, 0, 1'b0, 6'b0);
    check("beq_res_valid", res_valid, 1);
    check("beq_res_taken", res_taken, 1);
    check("beq_flush", flush, 0);
    check("beq_redir_valid", redir_valid, 0);
    check("beq_in_ready", in_ready, 1);
    check("beq_br", br_count, 1);
    check("beq_mis", mis_count, 0);
    tick();
    check("beq_res_pulse", res_valid, 0);

    // BNE taken, predicted not-taken, fetch stalls three cycles
    drive(1'b1, 3'd2, 32'h104, 32'h200, 1'b0, 6'b010000);
    tick();
    // wrong-path JUMP offered during the stall must be ignored
    drive(1'b1, 3'd7, 32'h500, 32'h600, 1'b0, 6'b0);
    check("bne_flush", flush, 1);
    check("bne_redir_valid", redir_valid, 1);
    check("bne_redir_pc", redir_pc, 32'h200);
    check("bne_in_ready", in_ready, 0);
    check("bne_res_taken", res_taken, 1);
    check("bne_br", br_count, 2);
    check("bne_mis", mis_count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_flush", flush, 0);
      check("stall_redir_valid", redir_valid, 1);
      check("stall_redir_pc", redir_pc, 32'h200);
      check("stall_in_ready", in_ready, 0);
      check("stall_res_valid", res_valid, 0);
      check("stall_br", br_count, 2);
    end
    drive(1'b0, 3'd0, 0, 0, 1'b0, 6'b0);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    check("bne_hs_redir_valid", redir_valid, 0);
    check("bne_hs_in_ready", in_ready, 1);
    check("bne_hs_mis", mis_count, 1);

    // BGEZ not taken, predicted taken, fetch ready immediately
    redir_ready = 1'b1;
    drive(1'b1, 3'd6, 32'h84, 32'h900, 1'b1, 6'b000000);
    tick();
    check("bgez_flush", flush, 1);
    check("bgez_redir_valid", redir_valid, 1);
    check("bgez_redir_pc", redir_pc, 32'h84);
    check("bgez_res_taken", res_taken, 0);
    check("bgez_br", br_count, 3);
    check("bgez_mis", mis_count, 2);
    drive(1'b1, 3'd1, 32'h88, 32'h300, 1'b1, 6'b100000);
    tick();
    check("bubble_redir_valid", redir_valid, 0);
    check("bubble_in_ready", in_ready, 1);
    check("bubble_res_valid", res_valid, 0);
    check("bubble_br", br_count, 3);
    tick();
    drive(1'b0, 3'd0, 0, 0, 1'b0, 6'b0);
    redir_ready = 1'b0;
    check("resume_res_valid", res_valid, 1);
    check("resume_res_taken", res_taken, 1);
    check("resume_flush", flush, 0);
    check("resume_br", br_count, 4);

    // clear, then 4 back-to-back correctly predicted JUMPs and a NONE
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_br", br_count, 0);
    check("clr_mis", mis_count, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd7, 32'h1000 + 32'(i * 4), 32'h2000, 1'b1, 6'b0);
      tick();
      check("jump_res_valid", res_valid, 1);
      check("jump_res_taken", res_taken, 1);
      check("jump_flush", flush, 0);
      check("jump_in_ready", in_ready, 1);
      check("jump_br", br_count, 32'(i + 1));
    end
    drive(1'b1, 3'd0, 32'h1010, 32'h2000, 1'b1, 6'b111111);
    tick();
    drive(1'b0, 3'd0, 0, 0, 1'b0, 6'b0);
    check("none_res_valid", res_valid, 0);
    check("none_flush", flush, 0);
    check("none_br", br_count, 4);
    check("none_mis", mis_count, 0);

    // saturation: 11 more branches reach 15, one more stays at 15
    drive(1'b1, 3'd7, 32'h40, 32'h80, 1'b1, 6'b0);
    for (int i = 0; i < 11; i++) tick();
    check("sat_reach_br", br_count, 15);
    tick();
    drive(1'b0, 3'd0, 0, 0, 1'b0, 6'b0);
    check("sat_hold_br", br_count, 15);
    check("sat_hold_res_valid", res_valid, 1);
    check("sat_mis", mis_count, 0);

    // cnt_clr coincident with a mispredicting accept
    cnt_clr = 1'b1;
    drive(1'b1, 3'd7, 32'h44, 32'h700, 1'b0, 6'b0);
    tick();
    cnt_clr = 1'b0;
    drive(1'b0, 3'd0, 0, 0, 1'b0, 6'b0);
    check("clrmis_flush", flush, 1);
    check("clrmis_redir_pc", redir_pc, 32'h700);
    check("clrmis_br", br_count, 0);
    check("clrmis_mis", mis_count, 0);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    check("clrmis_hs_in_ready", in_ready, 1);

    // BEQ not taken, predicted taken -> REDIRECT, then async reset
    drive(1'b1, 3'd1, 32'h204, 32'h800, 1'b1, 6'b010000);
    tick();
    drive(1'b0, 3'd0, 0, 0, 1'b0, 6'b0);
    check("pre_rst_redir_valid", redir_valid, 1);
    check("pre_rst_redir_pc", redir_pc, 32'h204);
    check("pre_rst_br", br_count, 1);
    check("pre_rst_mis", mis_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_redir_valid", redir_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_br", br_count, 0);
    check("async_mis", mis_count, 0);
    check("async_redir_pc", redir_pc, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_redir_valid", redir_valid, 0);
    check("post_rst_flush", flush, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumes the flag outputs of the comparator stage (eq/neq/slt/slte/sgt/sgte) together with branch metadata from EX.
- Evaluates the branch condition and checks it against the fetch-stage prediction.
- On a mispredict, issues a flush pulse and a held redirect (valid/ready) to fetch.
- Reports every resolution to the predictor and keeps saturating branch/mispredict counters.

Parameters:
WIDTH, 32, PC/target width in bits
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX presents a resolvable instruction
in_ready  out  1  block can accept; equals (state==IDLE)
in_op  in  3  branch op code (see Behaviour)
in_pc4  in  WIDTH  fall-through address (PC+4)
in_target  in  WIDTH  branch/jump target
in_pred_taken  in  1  fetch-stage prediction
eq, neq, slt, slte, sgt, sgte  in  1 each  comparator flags for this instruction (signed; b=0 for zero-compare ops)
redir_valid  out  1  redirect request to fetch
redir_ready  in  1  fetch accepts redirect
redir_pc  out  WIDTH  corrected fetch address
flush  out  1  one-cycle pulse: kill younger instructions
res_valid  out  1  one-cycle pulse: a branch resolved
res_taken  out  1  actual outcome, qualified by res_valid
cnt_clr  in  1  synchronous clear of both counters
br_count  out  CNT_W  resolved branches
mis_count  out  CNT_W  mispredicts

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - redir_valid, redir_pc, flush, res_valid, res_taken, br_count and mis_count are all 0.
  - in_ready=1 (state is IDLE); inputs are ignored while rst_n=0.
  - Reset asserted during REDIRECT abandons the redirect; redir_valid falls immediately.
- Op codes and taken condition:
  - 0 NONE: not a branch
  - 1 BEQ: eq
  - 2 BNE: neq
  - 3 BLEZ: slte
  - 4 BGTZ: sgt
  - 5 BLTZ: slt
  - 6 BGEZ: sgte
  - 7 JUMP: always taken
- Accept occurs when in_valid && in_ready (cycle N). All inputs are registered at that edge.
- Outputs in cycle N+1 (when op!=NONE):
  - res_valid=1 for exactly one cycle; res_taken = computed taken.
  - Correct prediction (taken==pred): no flush, state stays IDLE, in_ready stays 1. Back-to-back accepts are allowed every cycle.
  - Mispredict (taken!=pred): flush=1 for that cycle only, redir_valid=1, redir_pc = taken ? target : pc4, state=REDIRECT.
- op NONE: accepted, with no res_valid, no flush and no count change.
- REDIRECT state:
  - in_ready=0.
  - redir_valid and redir_pc are held stable until redir_ready=1.
  - On the handshake edge: state→IDLE, redir_valid→0.
  - If redir_ready=1 already in N+1, the handshake completes then and IDLE resumes at N+2, giving a minimum one-cycle bubble.
  - in_valid during REDIRECT is ignored (the instruction is wrong-path and flushed upstream).
- Counters:
  - br_count +1 per resolved branch (op!=NONE); mis_count +1 per mispredict.
  - Both update in the res_valid cycle and saturate at 2^CNT_W−1 (no wrap).
  - cnt_clr has priority over a simultaneous increment (result 0).
- No combinational path from in_* to any output other than none; in_ready depends only on state.

Decomposition:
- Shared package: op-code constants (OP_NONE..OP_JUMP) and a 1-bit state enum (IDLE, REDIRECT).
- Sub-module branch_cond: purely combinational op + flags → taken. It is reusable by a future early-branch unit in ID.

Test Plan:
- BEQ with eq=1, pred=1, target=0x400 → N+1: res_valid=1, res_taken=1, flush=0, redir_valid=0; br_count=1, mis_count=0; in_ready remains 1.
- BNE with neq=1, pred=0, pc4=0x104, target=0x200, redir_ready held 0 for 3 cycles:
  - N+1: flush pulse, redir_valid=1, redir_pc=0x200.
  - redir_valid/redir_pc stay stable and in_ready=0 throughout the stall.
  - Raising redir_ready clears redir_valid next edge; mis_count=1.
- BGEZ with sgte=0, pred=1, pc4=0x84 → redir_pc=0x84; with redir_ready=1 already, IDLE is resumed after one cycle and a new instruction is accepted.
- Back-to-back stream of 4 correctly predicted JUMPs then one NONE → four res_valid pulses, br_count=4, no flush.
- Saturation and clear:
  - Preload by issuing 2^CNT_W−1 branches (CNT_W=4 build: 15); one more branch leaves br_count=15.
  - cnt_clr asserted in the same cycle as a mispredict → both counters 0.
- rst_n pulsed low mid-REDIRECT (asynchronous, between edges) → redir_valid drops immediately; after release state=IDLE, in_ready=1, and the counters are 0.
